fdivsqrt_arb: RTL and testbench
===============================

Name: fdivsqrt_arb

Overview:
Round-robin arbiter and sequencer that shares one fdivsqrt divide/sqrt/integer-divide unit between NREQ requesters (e.g. FPU pipe and integer pipe, or per-hart ports). It accepts one operation at a time and issues a single-cycle start pulse to the unit. It waits for done, with a watchdog on the wait, then returns the result to the owning requester. It handles owner flushes by cancelling and draining the unit.

Parameters:
NREQ, 2, number of requesters (2..8)
OPW, 160, width of the packed operand/opcode bundle forwarded to the unit
RESW, 64, width of the unit result
CNTW, 7, watchdog counter width
MAXCYC, 100, cycles allowed between unit_start and unit_done before timeout

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset (asserted when 0)
req_valid  in  NREQ  request valid per requester
req_ready  out  NREQ  request accepted this cycle (one-hot or zero)
req_op  in  NREQ*OPW  operand bundle; slice i belongs to requester i
req_flush  in  NREQ  cancel requester i's in-flight operation
unit_start  out  1  one-cycle start pulse to the shared unit
unit_op  out  OPW  latched bundle of the granted request
unit_flush  out  1  one-cycle cancel to the unit
unit_busy  in  1  unit is iterating
unit_done  in  1  one-cycle completion pulse
unit_result  in  RESW  result, valid with unit_done
rsp_valid  out  NREQ  one-hot response valid
rsp_result  out  RESW  response data
rsp_err  out  1  response is a watchdog timeout (result forced to 0)
rsp_ready  in  NREQ  requester accepts response

Behaviour:
- Reset values: all outputs 0, state IDLE, RR pointer 0, unit_op 0, counter 0.
- States: IDLE, ISSUE, WAIT, RESP, DRAIN.
- IDLE: scan req_valid from ptr upward with wrap and pick the first set bit g. Assert req_ready[g] combinationally the same cycle. Latch req_op slice g into unit_op and record owner=g. Set ptr=(g+1) mod NREQ. Go to ISSUE. No grant when req_valid==0. req_flush[i] masks req_valid[i] that cycle.
- ISSUE: assert unit_start for exactly 1 cycle. Clear the counter. Go to WAIT. unit_op is held stable from ISSUE until leaving WAIT/DRAIN.
- WAIT, normal completion: on unit_done, capture unit_result, set rsp_err=0, go to RESP.
- WAIT, owner flush: req_flush[owner]=1 with no unit_done in the same cycle. Pulse unit_flush and go to DRAIN.
- WAIT, flush and done together: done wins. Go to RESP, then apply the RESP flush rule next cycle.
- WAIT, timeout: the counter increments each cycle. On reaching MAXCYC, pulse unit_flush, set the error flag, and go to DRAIN.
- RESP: rsp_valid[owner]=1 with stable rsp_result/rsp_err until rsp_ready[owner]. Then go to IDLE; a new grant is possible in the next cycle, not the same cycle.
- RESP with req_flush[owner]=1: drop the response (rsp_valid deasserts) and go to IDLE.
- DRAIN: wait until unit_busy==0, then leave.
  - Timeout case: go to RESP with rsp_err=1 and rsp_result=0.
  - Flush case: go to IDLE silently.
  - unit_done while in DRAIN is ignored.
- Flushes from non-owners are ignored in every state except IDLE masking.
- Minimum latency: accept at cycle t, unit_start at t+1, response at done+1.
- Async reset mid-operation clears all state immediately. The unit is not flushed by this block; system reset covers it.
- Assertions: unit_start and unit_flush are never asserted together; rsp_valid and req_ready are at most one-hot.

Test Plan:
- Single request: req_valid=01, unit_done 20 cycles after unit_start with unit_result=0x1234 -> req_ready[0] at t, unit_start at t+1, rsp_valid=01 with rsp_result=0x1234 one cycle after done, rsp_err=0.
- Fairness: req_valid=11 held continuously, unit done after 5 cycles each, rsp_ready=11 -> grants alternate 0,1,0,1; ptr wraps after requester NREQ-1.
- Owner flush in WAIT: flush[0] 3 cycles after start, unit_busy drops 2 cycles later -> one unit_flush pulse, no rsp_valid, IDLE after busy=0, next grant possible.
- Timeout: unit_done never asserted, MAXCYC=100 -> unit_flush at start+100, after busy=0 rsp_valid[owner] with rsp_err=1 and rsp_result=0.
- Response backpressure: rsp_ready low 7 cycles while req_valid[1]=1 -> rsp_result stable, req_ready stays 0 until the cycle after the handshake.
- Reset mid-WAIT: reset to 0 -> all outputs 0 immediately; after release the state is IDLE with ptr=0.

Source files
------------

// File: rtl/fdivsqrt_arb_if.sv
// Handshake bundle between the requesters, the arbiter and the shared divide/sqrt unit.
interface fdivsqrt_arb_if #(
    parameter int NREQ = 2,
    parameter int OPW  = 160,
    parameter int RESW = 64
);
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*OPW-1:0] req_op;
    logic [NREQ-1:0]     req_flush;
    logic                unit_start;
    logic [OPW-1:0]      unit_op;
    logic                unit_flush;
    logic                unit_busy;
    logic                unit_done;
    logic [RESW-1:0]     unit_result;
    logic [NREQ-1:0]     rsp_valid;
    logic [RESW-1:0]     rsp_result;
    logic                rsp_err;
    logic [NREQ-1:0]     rsp_ready;

    // arbiter side
    modport slave (
        input  req_valid, req_op, req_flush, unit_busy, unit_done, unit_result, rsp_ready,
        output req_ready, unit_start, unit_op, unit_flush, rsp_valid, rsp_result, rsp_err
    );

    // requester / unit side
    modport master (
        output req_valid, req_op, req_flush, unit_busy, unit_done, unit_result, rsp_ready,
        input  req_ready, unit_start, unit_op, unit_flush, rsp_valid, rsp_result, rsp_err
    );
endinterface

// File: rtl/fdivsqrt_arb.sv
// Round-robin arbiter/sequencer sharing one fdivsqrt unit between NREQ requesters.
//
//   state | meaning
//   IDLE  | scanning requests from ptr, grant accepted combinationally
//   ISSUE | one-cycle unit_start, watchdog cleared
//   WAIT  | waiting for unit_done, watchdog running
//   RESP  | holding response for the owner until rsp_ready
//   DRAIN | unit cancelled, waiting for unit_busy to drop
module fdivsqrt_arb #(
    parameter int NREQ   = 2,
    parameter int OPW    = 160,
    parameter int RESW   = 64,
    parameter int CNTW   = 7,
    parameter int MAXCYC = 100
) (
    input logic            clk,
    input logic            reset,
    fdivsqrt_arb_if.slave  bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   owner_q, owner_d;
    logic [OPW-1:0]  op_q, op_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [RESW-1:0] res_q, res_d;
    logic            err_q, err_d;

    logic [NREQ-1:0] req_eff;
    logic            gnt_found;
    logic [PW-1:0]   gnt_idx;
    logic            owner_flush;
    logic            timeout;

    logic [NREQ-1:0] req_ready;
    logic [NREQ-1:0] rsp_valid;
    logic            unit_start;
    logic            unit_flush;

    // a requester flushing this cycle is not eligible for a grant
    assign req_eff     = bus.req_valid & ~bus.req_flush;
    assign owner_flush = bus.req_flush[owner_q];
    // counter counts completed WAIT cycles; fires on the MAXCYC-th cycle after start
    assign timeout     = (cnt_q == CNTW'(MAXCYC - 1));

    // first eligible requester at or above ptr, wrapping
    always_comb begin
        int idx;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(ptr_q) + i) % NREQ;
            if (!gnt_found && req_eff[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = PW'(idx);
            end
        end
    end

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // datapath registers: pointer, owner, latched op, watchdog, response
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q   <= '0;
            owner_q <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

    // next-state and datapath update
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (gnt_found) begin
                    owner_d = gnt_idx;
                    op_d    = bus.req_op[gnt_idx*OPW +: OPW];
                    ptr_d   = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
                    err_d   = 1'b0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // done beats a same-cycle flush; the flush is then seen in RESP
                if (bus.unit_done) begin
                    res_d   = bus.unit_result;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (owner_flush) begin
                    err_d   = 1'b0;
                    state_d = DRAIN;
                end else if (timeout) begin
                    res_d   = '0;
                    err_d   = 1'b1;
                    state_d = DRAIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (owner_flush || bus.rsp_ready[owner_q]) state_d = IDLE;
            end
            DRAIN: begin
                // only a timeout drain produces a (error) response
                if (!bus.unit_busy) state_d = err_q ? RESP : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // outputs decoded from state
    always_comb begin
        req_ready  = '0;
        rsp_valid  = '0;
        unit_start = 1'b0;
        unit_flush = 1'b0;
        case (state_q)
            IDLE:    if (reset && gnt_found) req_ready[gnt_idx] = 1'b1;
            ISSUE:   unit_start = 1'b1;
            WAIT:    unit_flush = !bus.unit_done && (owner_flush || timeout);
            RESP:    if (!owner_flush) rsp_valid[owner_q] = 1'b1;
            default: ;
        endcase
    end

    assign bus.req_ready  = req_ready;
    assign bus.rsp_valid  = rsp_valid;
    assign bus.unit_start = unit_start;
    assign bus.unit_flush = unit_flush;
    assign bus.unit_op    = op_q;
    assign bus.rsp_result = res_q;
    assign bus.rsp_err    = err_q;

    // start/flush exclusive, grants and responses at most one-hot
    always_ff @(posedge clk) begin
        if (reset) begin
            assert (!(unit_start && unit_flush));
            assert ($onehot0(rsp_valid));
            assert ($onehot0(req_ready));
        end
    end
endmodule

// File: tb/tb_fdivsqrt_arb.sv
// Directed bench for fdivsqrt_arb: single op, fairness, flush, timeout, backpressure, reset.
module tb_fdivsqrt_arb;
    localparam int NREQ   = 2;
    localparam int OPW    = 160;
    localparam int RESW   = 64;
    localparam int CNTW   = 7;
    localparam int MAXCYC = 100;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   tests = 0;
    int   fails = 0;

    logic [OPW-1:0] op0 = 160'h0000_0000_0000_0000_0000_0000_A0A0_0000_0000_1111;
    logic [OPW-1:0] op1 = 160'h1234_0000_0000_0000_0000_0000_B1B1_0000_0000_2222;

    fdivsqrt_arb_if #(.NREQ(NREQ), .OPW(OPW), .RESW(RESW)) bus ();

    fdivsqrt_arb #(
        .NREQ(NREQ), .OPW(OPW), .RESW(RESW), .CNTW(CNTW), .MAXCYC(MAXCYC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"},  bus.req_ready,  0);
        check({tag, "_unit_start"}, bus.unit_start, 0);
        check({tag, "_unit_flush"}, bus.unit_flush, 0);
        check({tag, "_unit_op"},    bus.unit_op,    0);
        check({tag, "_rsp_valid"},  bus.rsp_valid,  0);
        check({tag, "_rsp_result"}, bus.rsp_result, 0);
        check({tag, "_rsp_err"},    bus.rsp_err,    0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "time limit");
    end

    initial begin
        int g;
        logic [1:0] oh;
        bus.req_valid   = '0;
        bus.req_flush   = '0;
        bus.req_op      = {op1, op0};
        bus.unit_busy   = 1'b0;
        bus.unit_done   = 1'b0;
        bus.unit_result = '0;
        bus.rsp_ready   = '0;

        // reset state
        #12;
        check_all_zero("reset");
        tick();
        reset = 1'b1;

        // single request, done 20 cycles after start
        bus.req_valid = 2'b01; #1;
        check("t1_ready", bus.req_ready, 2'b01);
        tick();                                   // ISSUE
        bus.req_valid = 2'b00; #1;
        check("t1_start", bus.unit_start, 1);
        check("t1_op", bus.unit_op, op0);
        tick();                                   // start+1
        bus.unit_busy = 1'b1; #1;
        check("t1_start_pulse", bus.unit_start, 0);
        repeat (18) tick();                       // start+19
        tick();                                   // start+20
        bus.unit_done = 1'b1; bus.unit_result = 64'h1234; #1;
        check("t1_no_rsp_yet", bus.rsp_valid, 0);
        check("t1_op_held", bus.unit_op, op0);
        tick();
        bus.unit_done = 1'b0; bus.unit_busy = 1'b0; #1;
        check("t1_rsp_valid", bus.rsp_valid, 2'b01);
        check("t1_rsp_result", bus.rsp_result, 64'h1234);
        check("t1_rsp_err", bus.rsp_err, 0);
        bus.rsp_ready = 2'b01; #1;
        tick();
        bus.rsp_ready = 2'b00; #1;
        check("t1_rsp_done", bus.rsp_valid, 0);

        // fairness: ptr is 1 after granting 0, so grants go 1,0,1,0
        bus.req_valid = 2'b11;
        bus.rsp_ready = 2'b11;
        g = 1;
        for (int k = 0; k < 4; k++) begin
            oh = 2'b01 << g;
            #1;
            check("fair_grant", bus.req_ready, oh);
            tick();
            check("fair_start", bus.unit_start, 1);
            check("fair_op", bus.unit_op, (g == 1) ? op1 : op0);
            repeat (4) tick();
            tick();                               // start+5
            bus.unit_done = 1'b1; bus.unit_result = 64'h100 + 64'(k);
            tick();
            bus.unit_done = 1'b0; #1;
            check("fair_rsp_valid", bus.rsp_valid, oh);
            check("fair_rsp_result", bus.rsp_result, 64'h100 + 64'(k));
            check("fair_no_grant_in_resp", bus.req_ready, 0);
            tick();
            g = 1 - g;
        end
        bus.rsp_ready = 2'b00;

        // owner flush in WAIT, busy drops two cycles after the flush
        bus.req_valid = 2'b01; #1;
        check("fl_grant", bus.req_ready, 2'b01);
        tick();                                   // s
        bus.req_valid = 2'b00;
        tick();                                   // s+1
        bus.unit_busy = 1'b1;
        tick();                                   // s+2
        tick();                                   // s+3
        bus.req_flush = 2'b01; #1;
        check("fl_unit_flush", bus.unit_flush, 1);
        check("fl_no_rsp", bus.rsp_valid, 0);
        tick();                                   // s+4, DRAIN
        bus.req_flush = 2'b00; bus.req_valid = 2'b10; #1;
        check("fl_flush_pulse", bus.unit_flush, 0);
        check("fl_drain_no_grant", bus.req_ready, 0);
        tick();                                   // s+5
        bus.unit_busy = 1'b0; #1;
        check("fl_drain_no_grant2", bus.req_ready, 0);
        check("fl_no_rsp2", bus.rsp_valid, 0);
        tick();                                   // IDLE
        check("fl_next_grant", bus.req_ready, 2'b10);

        // timeout: owner 1, done never arrives
        tick();                                   // s'
        bus.req_valid = 2'b00; #1;
        check("to_start", bus.unit_start, 1);
        bus.unit_busy = 1'b1;
        repeat (99) begin
            tick();
            check("to_no_flush_early", bus.unit_flush, 0);
        end
        tick();                                   // s'+100
        check("to_unit_flush", bus.unit_flush, 1);
        check("to_no_rsp", bus.rsp_valid, 0);
        tick();                                   // DRAIN
        check("to_flush_pulse", bus.unit_flush, 0);
        bus.unit_done = 1'b1; bus.unit_result = 64'hDEAD; #1;
        check("to_drain_no_rsp", bus.rsp_valid, 0);
        tick();
        bus.unit_done = 1'b0; bus.unit_busy = 1'b0; #1;
        check("to_drain_no_rsp2", bus.rsp_valid, 0);
        tick();                                   // RESP
        check("to_rsp_valid", bus.rsp_valid, 2'b10);
        check("to_rsp_err", bus.rsp_err, 1);
        check("to_rsp_result", bus.rsp_result, 0);
        bus.rsp_ready = 2'b10; #1;
        tick();
        bus.rsp_ready = 2'b00;

        // response backpressure with requester 1 waiting
        bus.req_valid = 2'b01; #1;
        check("bp_grant", bus.req_ready, 2'b01);
        tick();                                   // ISSUE
        bus.req_valid = 2'b10;
        tick();                                   // WAIT
        bus.unit_done = 1'b1; bus.unit_result = 64'hBEEF; #1;
        check("bp_wait_no_grant", bus.req_ready, 0);
        tick();                                   // RESP
        bus.unit_done = 1'b0;
        repeat (7) begin
            #1;
            check("bp_rsp_valid", bus.rsp_valid, 2'b01);
            check("bp_rsp_result", bus.rsp_result, 64'hBEEF);
            check("bp_no_grant", bus.req_ready, 0);
            tick();
        end
        bus.rsp_ready = 2'b01; #1;
        check("bp_hs_valid", bus.rsp_valid, 2'b01);
        check("bp_hs_no_grant", bus.req_ready, 0);
        tick();
        bus.rsp_ready = 2'b00; #1;
        check("bp_rsp_gone", bus.rsp_valid, 0);
        check("bp_next_grant", bus.req_ready, 2'b10);

        // done and owner flush together: done wins, response then dropped
        tick();                                   // ISSUE, owner 1
        bus.req_valid = 2'b01;
        tick();                                   // WAIT
        bus.unit_done = 1'b1; bus.unit_result = 64'h55; bus.req_flush = 2'b10; #1;
        check("df_no_unit_flush", bus.unit_flush, 0);
        tick();                                   // RESP
        bus.unit_done = 1'b0; #1;
        check("df_rsp_dropped", bus.rsp_valid, 0);
        tick();                                   // IDLE
        bus.req_flush = 2'b00; #1;
        check("df_next_grant", bus.req_ready, 2'b01);

        // reset in the middle of WAIT (ptr is 1 before reset)
        tick();                                   // ISSUE
        bus.req_valid = 2'b10;
        tick();                                   // WAIT
        bus.unit_busy = 1'b1;
        tick();
        reset = 1'b0; #1;
        check_all_zero("rst_mid");
        tick();
        reset = 1'b1; bus.unit_busy = 1'b0;
        bus.req_valid = 2'b11; bus.req_flush = 2'b01; #1;
        check("rst_flush_mask", bus.req_ready, 2'b10);
        bus.req_flush = 2'b00; #1;
        check("rst_ptr_zero", bus.req_ready, 2'b01);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
